// File: rtl/genomics_base_packer.sv
// rtl/genomics_base_packer.sv - ASCII nucleotide to 2-bit base code packer (optional stats: GENOMICS_PACKER_STATS_EN)
module genomics_base_packer #(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_IN_BYTES   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              in_ready,
    input  logic                              in_avail,
    input  logic [8*C_IN_BYTES-1:0]           in_data,
    input  logic                              in_last,
    input  logic                              out_ready,
    output logic                              out_avail,
    output logic [C_DATA_WIDTH-1:0]           out_data,
    output logic                              out_last,
    output logic [$clog2(C_DATA_WIDTH/2):0]   out_count,
    output logic [31:0]                       invalid_count
);

    localparam int BASES     = C_DATA_WIDTH / 2;
    localparam int BPW       = BASES / C_IN_BYTES;
    localparam int BEAT_BITS = 2 * C_IN_BYTES;
    localparam int BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW        = $clog2(BASES) + 1;

    typedef enum logic {
        FILLING = 1'b0,
        HOLDING = 1'b1
    } state_t;

    state_t                  state;
    logic [C_DATA_WIDTH-1:0] accum;
    logic [C_DATA_WIDTH-1:0] accum_next;
    logic [BCW-1:0]          beat_cnt;
    logic [BEAT_BITS-1:0]    beat_codes;
    logic [CW-1:0]           count_next;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    last_beat;
    logic                    word_done;

    // Case-insensitive ACGT mapping; anything else encodes as 0
    function automatic logic [1:0] encode_base(input logic [7:0] ch);
        logic [1:0] code;
        case (ch)
            8'h41, 8'h61: code = 2'd0;
            8'h43, 8'h63: code = 2'd1;
            8'h47, 8'h67: code = 2'd2;
            8'h54, 8'h74: code = 2'd3;
            default:      code = 2'd0;
        endcase
        return code;
    endfunction

    function automatic logic is_acgt(input logic [7:0] ch);
        logic ok;
        case (ch)
            8'h41, 8'h61, 8'h43, 8'h63,
            8'h47, 8'h67, 8'h54, 8'h74: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The only stall source is a held word that downstream has not taken
    assign in_ready  = (state == FILLING) || out_ready;
    assign out_avail = (state == HOLDING);
    assign in_xfer   = in_ready && in_avail;
    assign out_xfer  = out_ready && out_avail;
    assign last_beat = (beat_cnt == BCW'(BPW - 1));
    assign word_done = in_xfer && (last_beat || in_last);
    assign count_next = CW'((int'(beat_cnt) + 1) * C_IN_BYTES);

    // Encode every character of the current beat; byte 0 is the earliest base
    always_comb begin
        beat_codes = '0;
        for (int j = 0; j < C_IN_BYTES; j++) begin
            beat_codes[2*j +: 2] = encode_base(in_data[8*j +: 8]);
        end
    end

    // Accumulator with this beat's codes dropped into the slot picked by beat_cnt
    always_comb begin
        accum_next = accum;
        for (int b = 0; b < BPW; b++) begin
            if (beat_cnt == BCW'(b)) begin
                accum_next[b*BEAT_BITS +: BEAT_BITS] = beat_codes;
            end
        end
    end

    // FILLING/HOLDING control, accumulator, beat counter and output holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILLING;
            accum     <= '0;
            beat_cnt  <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
        end else begin
            if (word_done) begin
                // A completing beat refills the holding register even while the
                // previous word is leaving in this same cycle
                state     <= HOLDING;
                out_data  <= accum_next;
                out_count <= count_next;
                out_last  <= in_last;
                accum     <= '0;
                beat_cnt  <= '0;
            end else begin
                if (in_xfer) begin
                    accum    <= accum_next;
                    beat_cnt <= beat_cnt + BCW'(1);
                end
                if (out_xfer) begin
                    state <= FILLING;
                end
            end
        end
    end

`ifdef GENOMICS_PACKER_STATS_EN
    localparam int IBW = $clog2(C_IN_BYTES + 1);

    logic [IBW-1:0] inv_beat;
    logic [32:0]    inv_sum;
    logic [31:0]    inv_reg;

    // Number of non-ACGT characters in the current beat and the widened running sum
    always_comb begin
        inv_beat = '0;
        for (int j = 0; j < C_IN_BYTES; j++) begin
            if (!is_acgt(in_data[8*j +: 8])) begin
                inv_beat = inv_beat + IBW'(1);
            end
        end
        inv_sum = {1'b0, inv_reg} + 33'(inv_beat);
    end

    // Saturating invalid-character counter, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inv_reg <= '0;
        end else if (in_xfer) begin
            inv_reg <= inv_sum[32] ? 32'hFFFF_FFFF : inv_sum[31:0];
        end
    end

    assign invalid_count = inv_reg;
`else
    assign invalid_count = 32'd0;
`endif

endmodule

// File: tb/tb_genomics_base_packer.sv
// tb/tb_genomics_base_packer.sv - directed and throttled-random bench for genomics_base_packer
module tb_genomics_base_packer;

    localparam int DW = 512;
    localparam int IB = 4;
    localparam int CW = 9;

`ifdef GENOMICS_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_ready;
    logic          in_avail;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_ready;
    logic          out_avail;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] out_count;
    logic [31:0]   invalid_count;

    genomics_base_packer #(.C_DATA_WIDTH(DW), .C_IN_BYTES(IB)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_ready      (in_ready),
        .in_avail      (in_avail),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_ready     (out_ready),
        .out_avail     (out_avail),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_count     (out_count),
        .invalid_count (invalid_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] obs_data [$];
    logic [CW-1:0] obs_count[$];
    logic          obs_last [$];
    logic [DW-1:0] exp_data [$];
    logic [CW-1:0] exp_count[$];
    logic          exp_last [$];

    logic [DW-1:0] m_acc;
    int            m_cnt;
    logic [31:0]   m_inv;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            throttle = 1'b0;
    logic [7:0]    chars [9];

    // Output words are captured on the falling edge ahead of the edge that takes them
    always @(negedge clk) begin
        if (reset && out_avail && out_ready) begin
            obs_data.push_back(out_data);
            obs_count.push_back(out_count);
            obs_last.push_back(out_last);
        end
    end

    function automatic logic [1:0] tb_code(input logic [7:0] b);
        case (b)
            8'h41, 8'h61: return 2'd0;
            8'h43, 8'h63: return 2'd1;
            8'h47, 8'h67: return 2'd2;
            8'h54, 8'h74: return 2'd3;
            default:      return 2'd0;
        endcase
    endfunction

    function automatic bit tb_bad(input logic [7:0] b);
        case (b)
            8'h41, 8'h61, 8'h43, 8'h63, 8'h47, 8'h67, 8'h54, 8'h74: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_cnt = 0;
        m_inv = '0;
        obs_data.delete(); obs_count.delete(); obs_last.delete();
        exp_data.delete(); exp_count.delete(); exp_last.delete();
    endtask

    task automatic model_accept(input logic [31:0] d, input logic l);
        for (int j = 0; j < IB; j++) begin
            m_acc[(m_cnt*IB + j)*2 +: 2] = tb_code(d[8*j +: 8]);
            if (tb_bad(d[8*j +: 8])) m_inv = m_inv + 32'd1;
        end
        m_cnt++;
        if (m_cnt == 64 || l) begin
            exp_data.push_back(m_acc);
            exp_count.push_back(CW'(m_cnt * IB));
            exp_last.push_back(l);
            m_acc = '0;
            m_cnt = 0;
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Drives one beat starting at posedge+1 and returns at posedge+1 after it is accepted
    task automatic send(input logic [31:0] d, input logic l);
        int waited;
        waited   = 0;
        in_avail = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 3000) begin
            @(posedge clk); #1;
            if (throttle) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready 0 expected 1 within 3000 cycles");
            finish_now();
        end
        model_accept(d, l);
        @(posedge clk); #1;
        in_avail = 1'b0;
        if (throttle) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pop_word(input string tag, input logic [DW-1:0] d, input int c, input logic l);
        check({tag, "_present"}, 512'(obs_data.size() > 0), 512'(1));
        if (obs_data.size() > 0) begin
            check({tag, "_data"},  obs_data.pop_front(), d);
            check({tag, "_count"}, 512'(obs_count.pop_front()), 512'(c));
            check({tag, "_last"},  512'(obs_last.pop_front()), 512'(l));
        end
    endtask

    task automatic do_reset(input string tag);
        in_avail = 1'b1;
        in_data  = 32'h54545454;
        in_last  = 1'b1;
        reset    = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check({tag, "_avail"},   512'(out_avail), 512'(0));
        check({tag, "_count"},   512'(out_count), 512'(0));
        check({tag, "_data"},    out_data, 512'(0));
        check({tag, "_invalid"}, 512'(invalid_count), 512'(0));
        @(posedge clk); #1;
        reset    = 1'b1;
        in_avail = 1'b0;
        in_last  = 1'b0;
        model_clear();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] e_acgt;
        logic [DW-1:0] e_w1;
        logic [DW-1:0] e_w2;
        logic [DW-1:0] e_c;
        logic [31:0]   d;
        logic          l;
        int            nw;

        chars = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74, 8'h4E};
        for (int i = 0; i < 64; i++) begin
            e_acgt[8*i +: 8] = 8'hE4;
            e_c[8*i +: 8]    = 8'h55;
        end
        e_w1 = {32{16'hFF00}};
        e_w2 = {32{16'hAA55}};

        // Reset state, with in_avail asserted and ignored during reset
        reset     = 1'b0;
        in_avail  = 1'b1;
        in_data   = 32'h41414141;
        in_last   = 1'b1;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_avail",   512'(out_avail), 512'(0));
        check("rst_last",    512'(out_last), 512'(0));
        check("rst_count",   512'(out_count), 512'(0));
        check("rst_data",    out_data, 512'(0));
        check("rst_invalid", 512'(invalid_count), 512'(0));
        @(posedge clk); #1;
        reset    = 1'b1;
        in_avail = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 512'(in_ready), 512'(1));
        check("post_rst_avail", 512'(out_avail), 512'(0));
        @(posedge clk); #1;

        // Full word of ACGT closed by in_last on beat 64, with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 63; i++) send(32'h54474341, 1'b0);
        in_avail = 1'b1;
        in_data  = 32'h54474341;
        in_last  = 1'b1;
        @(negedge clk);
        check("t1_avail_before", 512'(out_avail), 512'(0));
        check("t1_ready_before", 512'(in_ready), 512'(1));
        model_accept(32'h54474341, 1'b1);
        @(posedge clk); #1;
        in_avail = 1'b0;
        in_last  = 1'b0;
        check("t1_avail_after", 512'(out_avail), 512'(1));
        check("t1_data",  out_data, e_acgt);
        check("t1_count", 512'(out_count), 512'(256));
        check("t1_last",  512'(out_last), 512'(1));
        wait_cycles(3);
        check("t1_drained", 512'(out_avail), 512'(0));
        pop_word("t1_word", e_acgt, 256, 1'b1);

        // Short sequence, mixed case
        send(32'h74676361, 1'b0);
        send(32'h54545454, 1'b0);
        send(32'h41434747, 1'b1);
        wait_cycles(3);
        pop_word("t2_word", 512'h1AFFE4, 12, 1'b1);

        // Backpressure: word 1 held while the input stalls, then both words drain
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send((i % 2) ? 32'h54545454 : 32'h41414141, 1'b0);
        in_avail = 1'b1;
        in_data  = 32'h43434343;
        in_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_stall_ready", 512'(in_ready), 512'(0));
            check("t3_hold_avail",  512'(out_avail), 512'(1));
            check("t3_hold_data",   out_data, e_w1);
            check("t3_hold_last",   512'(out_last), 512'(0));
            @(posedge clk); #1;
        end
        check("t3_no_early_word", 512'(obs_data.size()), 512'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send((i % 2) ? 32'h47474747 : 32'h43434343, i == 63);
        wait_cycles(3);
        check("t3_word_total", 512'(obs_data.size()), 512'(2));
        pop_word("t3_word1", e_w1, 256, 1'b0);
        pop_word("t3_word2", e_w2, 256, 1'b1);

        // Invalid characters encode as 0 and are counted only with stats built in
        check("t4_inv_before", 512'(invalid_count), 512'(0));
        send(32'h544E4E41, 1'b1);
        wait_cycles(3);
        pop_word("t4_word", 512'hC0, 4, 1'b1);
        check("t4_inv_after", 512'(invalid_count), 512'(STATS ? 32'd2 : 32'd0));

        // Reset mid-word and mid-hold discards everything
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h47474747, 1'b0);
        do_reset("t5_rst_partial");
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(32'h47474747, 1'b0);
        @(negedge clk);
        check("t5_held_before_rst", 512'(out_avail), 512'(1));
        @(posedge clk); #1;
        do_reset("t5_rst_hold");
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(32'h43434343, 1'b0);
        wait_cycles(3);
        check("t5_word_total", 512'(obs_data.size()), 512'(1));
        pop_word("t5_word", e_c, 256, 1'b0);

        // Throttled random traffic against the reference packing model
        model_clear();
        throttle = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            for (int j = 0; j < IB; j++) d[8*j +: 8] = chars[$urandom_range(0, 8)];
            l = ($urandom_range(0, 19) == 0);
            send(d, l || (i == 1499));
        end
        throttle  = 1'b0;
        out_ready = 1'b1;
        wait_cycles(4);
        check("rnd_drained", 512'(out_avail), 512'(0));
        check("rnd_word_total", 512'(obs_data.size()), 512'(exp_data.size()));
        nw = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < nw; i++) begin
            check("rnd_data",  obs_data[i], exp_data[i]);
            check("rnd_count", 512'(obs_count[i]), 512'(exp_count[i]));
            check("rnd_last",  512'(obs_last[i]), 512'(exp_last[i]));
        end
        check("rnd_invalid", 512'(invalid_count), 512'(STATS ? m_inv : 32'd0));

        finish_now();
    end

endmodule
